// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and constants for the two-requester register bank arbiter.
package reg_bank_arbiter_pkg;

  localparam int DW = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    DONE    = 3'd2,
    CLEAR   = 3'd3,
    CLRDONE = 3'd4
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Round-robin hand-off: the requester that was just served yields priority.
  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_bank.sv
// Register storage: plain 8-bit flops without load enable, plus the bank
// wrapper that recirculates Q into D except where the write select is hot.

module reg8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic [7:0] d,
  output logic [7:0] q
);

  // Synchronous reset wins over set; otherwise load D every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 8'h00;
    end else if (set) begin
      q <= 8'hFF;
    end else begin
      q <= d;
    end
  end

endmodule

module reg_bank
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic [NREG-1:0]    wsel_i,
  input  logic [DW-1:0]      wdata_i,
  output logic [NREG*DW-1:0] q_o
);

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    logic [DW-1:0] d;

    // Selected register takes new data, the rest hold their value.
    always_comb begin
      d = wsel_i[g] ? wdata_i : q_o[g*DW +: DW];
    end

    reg8 u_reg8 (
      .clk (clk),
      .rst (rst_i),
      .set (1'b0),
      .d   (d),
      .q   (q_o[g*DW +: DW])
    );
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter sequencing reads, writes and bulk clears
// of a shared 8-bit register bank.
//
// state   | meaning
// IDLE    | waiting; clear has priority, else pick a requester
// ACCESS  | winner's gnt high; write lands / read captured at end of cycle
// DONE    | winner's done high; rdata valid
// CLEAR   | bank sync reset asserted for one cycle
// CLRDONE | clr_done high

module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_done,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_done,
  input  logic          clr_req,
  output logic          clr_done,
  output logic [DW-1:0] rdata
);

  state_e             state_q;
  req_id_e            rr_q;
  req_id_e            cmd_who_q;
  req_id_e            win_d;
  logic               cmd_we_q;
  logic [AW-1:0]      cmd_addr_q;
  logic [DW-1:0]      cmd_wdata_q;
  logic               a_gnt_q;
  logic               b_gnt_q;
  logic               a_done_q;
  logic               b_done_q;
  logic               clr_done_q;
  logic [DW-1:0]      rdata_q;
  logic [DW-1:0]      rd_val_d;
  logic               bank_rst;
  logic [NREG-1:0]    wsel;
  logic [NREG*DW-1:0] bank_q;

  // Winner when both request: whoever rr points at; a lone request always wins.
  always_comb begin
    win_d = REQ_A;
    if (b_req && (!a_req || rr_q == REQ_B)) begin
      win_d = REQ_B;
    end
  end

  // One-hot write select; out-of-range addresses match nothing and so recirculate.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < NREG; i++) begin
      wsel[i] = (state_q == ACCESS) && cmd_we_q && (cmd_addr_q == AW'(i));
    end
  end

  // Read mux; addresses with no register behind them read as zero.
  always_comb begin
    rd_val_d = '0;
    for (int i = 0; i < NREG; i++) begin
      if (cmd_addr_q == AW'(i)) begin
        rd_val_d = bank_q[i*DW +: DW];
      end
    end
  end

  // Bank is held cleared through system reset so an interrupted write never sticks.
  always_comb begin
    bank_rst = !reset_n || (state_q == CLEAR);
  end

  // Sequencing FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_q        <= REQ_A;
      cmd_who_q   <= REQ_A;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      clr_done_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      clr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
          end else if (a_req || b_req) begin
            cmd_who_q <= win_d;
            if (win_d == REQ_A) begin
              cmd_we_q    <= a_we;
              cmd_addr_q  <= a_addr;
              cmd_wdata_q <= a_wdata;
              a_gnt_q     <= 1'b1;
            end else begin
              cmd_we_q    <= b_we;
              cmd_addr_q  <= b_addr;
              cmd_wdata_q <= b_wdata;
              b_gnt_q     <= 1'b1;
            end
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          rr_q <= other_req(cmd_who_q);
          if (!cmd_we_q) begin
            rdata_q <= rd_val_d;
          end
          if (cmd_who_q == REQ_A) begin
            a_done_q <= 1'b1;
          end else begin
            b_done_q <= 1'b1;
          end
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        CLEAR: begin
          clr_done_q <= 1'b1;
          state_q    <= CLRDONE;
        end
        CLRDONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  reg_bank #(
    .NREG (NREG)
  ) u_bank (
    .clk     (clk),
    .rst_i   (bank_rst),
    .wsel_i  (wsel),
    .wdata_i (cmd_wdata_q),
    .q_o     (bank_q)
  );

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_done   = a_done_q;
  assign b_done   = b_done_q;
  assign clr_done = clr_done_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: an 8-register and a 6-register instance share
// the same stimulus; sel6 chooses which one is being checked.
module tb_reg_bank_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_req, a_we, b_req, b_we, clr_req;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;

  logic       a_gnt8, a_done8, b_gnt8, b_done8, clr_done8;
  logic [7:0] rdata8;
  logic       a_gnt6, a_done6, b_gnt6, b_done6, clr_done6;
  logic [7:0] rdata6;

  logic       sel6 = 1'b0;
  logic       o_a_gnt, o_a_done, o_b_gnt, o_b_done, o_clr_done;
  logic [7:0] o_rdata;

  assign o_a_gnt    = sel6 ? a_gnt6    : a_gnt8;
  assign o_a_done   = sel6 ? a_done6   : a_done8;
  assign o_b_gnt    = sel6 ? b_gnt6    : b_gnt8;
  assign o_b_done   = sel6 ? b_done6   : b_done8;
  assign o_clr_done = sel6 ? clr_done6 : clr_done8;
  assign o_rdata    = sel6 ? rdata6    : rdata8;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.NREG(8), .AW(3)) u_dut8 (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt8), .a_done(a_done8),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt8), .b_done(b_done8),
    .clr_req(clr_req), .clr_done(clr_done8), .rdata(rdata8)
  );

  reg_bank_arbiter #(.NREG(6), .AW(3)) u_dut6 (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt6), .a_done(a_done6),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt6), .b_done(b_done6),
    .clr_req(clr_req), .clr_done(clr_done6), .rdata(rdata6)
  );

  typedef struct {
    bit         who;
    logic [7:0] rdata;
  } sb_t;

  typedef struct {
    bit         n6;
    bit         who;
    bit         we;
    logic [2:0] addr;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[$];
  sb_t  mon_e;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add(input bit n6, input bit who, input bit we, input logic [2:0] addr,
                     input logic [7:0] wd, input logic [7:0] exp);
    vec_t v;
    v.n6 = n6; v.who = who; v.we = we; v.addr = addr; v.wd = wd; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Scoreboard: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (o_a_done || o_b_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", {o_a_done, o_b_done}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        chk("done_owner", {o_a_done, o_b_done}, mon_e.who ? 2'b01 : 2'b10);
        chk("done_rdata", o_rdata, mon_e.rdata);
      end
    end
  end

  task automatic do_access(input bit who, input bit we, input logic [2:0] addr,
                           input logic [7:0] wd, input logic [7:0] exp,
                           output int glat, output int dlat);
    sb_t e;
    bit  got;
    int  start;
    e.who = who; e.rdata = exp;
    sb.push_back(e);
    if (!who) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end
    glat = 0; dlat = 0; got = 1'b0;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk);
      if (who ? o_b_gnt : o_a_gnt) begin
        got = 1'b1;
        glat = i;
      end
    end
    chk("gnt_seen", got, 1'b1);
    a_req = 1'b0; b_req = 1'b0;
    start = done_cnt;
    got = 1'b0;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != start) begin
        got = 1'b1;
        dlat = i;
      end
    end
    chk("done_seen", got, 1'b1);
    if (!got && sb.size() > 0) void'(sb.pop_back());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  gl, dl, start;
    bit  saw_clr, got_b;
    sb_t e;

    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    clr_req = 0;
    repeat (3) @(negedge clk);
    chk("reset_pulses8", {a_gnt8, a_done8, b_gnt8, b_done8, clr_done8}, 5'b0);
    chk("reset_rdata8", rdata8, 8'h00);
    chk("reset_rdata6", rdata6, 8'h00);
    reset_n = 1'b1;

    // First access straight out of reset: gnt one cycle after the request, done one later.
    do_access(0, 1, 3'd3, 8'h5A, 8'h00, gl, dl);
    chk("first_gnt_latency", gl, 1);
    chk("first_done_latency", dl, 1);

    //   n6 who we addr  wdata  expected rdata at done
    add(0, 0, 0, 3'd3, 8'h00, 8'h5A);
    add(0, 1, 1, 3'd5, 8'hC3, 8'h5A);
    add(0, 1, 0, 3'd5, 8'h00, 8'hC3);
    add(0, 0, 0, 3'd0, 8'h00, 8'h00);
    add(0, 1, 1, 3'd7, 8'hFF, 8'h00);
    add(0, 0, 0, 3'd7, 8'h00, 8'hFF);
    add(0, 1, 0, 3'd3, 8'h00, 8'h5A);
    add(1, 0, 0, 3'd3, 8'h00, 8'h5A);
    add(1, 0, 1, 3'd0, 8'hA0, 8'h5A);
    add(1, 1, 1, 3'd1, 8'hA1, 8'h5A);
    add(1, 0, 1, 3'd2, 8'hA2, 8'h5A);
    add(1, 1, 1, 3'd3, 8'hA3, 8'h5A);
    add(1, 0, 1, 3'd4, 8'hA4, 8'h5A);
    add(1, 1, 1, 3'd5, 8'hA5, 8'h5A);
    add(1, 0, 1, 3'd7, 8'hFF, 8'h5A);
    add(1, 1, 1, 3'd6, 8'hEE, 8'h5A);
    add(1, 0, 0, 3'd0, 8'h00, 8'hA0);
    add(1, 1, 0, 3'd1, 8'h00, 8'hA1);
    add(1, 0, 0, 3'd2, 8'h00, 8'hA2);
    add(1, 1, 0, 3'd3, 8'h00, 8'hA3);
    add(1, 0, 0, 3'd4, 8'h00, 8'hA4);
    add(1, 1, 0, 3'd5, 8'h00, 8'hA5);
    add(1, 0, 0, 3'd7, 8'h00, 8'h00);
    add(1, 1, 0, 3'd6, 8'h00, 8'h00);
    foreach (vecs[i]) begin
      sel6 = vecs[i].n6;
      do_access(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].exp, gl, dl);
    end
    sel6 = 1'b0;

    // Both requesters held: last grant was B, so order must be A, B, A, B.
    for (int i = 0; i < 4; i++) begin
      e.who = i[0]; e.rdata = 8'hEE;
      sb.push_back(e);
    end
    a_req = 1; a_we = 1; a_addr = 3'd1; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 3'd2; b_wdata = 8'h22;
    start = done_cnt;
    for (int i = 0; i < 40 && (done_cnt - start) < 4; i++) begin
      @(negedge clk);
      #1;
    end
    a_req = 0; b_req = 0;
    chk("fair_done_count", done_cnt - start, 4);
    chk("fair_sb_empty", sb.size(), 0);
    sb.delete();
    do_access(0, 0, 3'd1, 8'h00, 8'h11, gl, dl);
    do_access(1, 0, 3'd2, 8'h00, 8'h22, gl, dl);

    // Fill, then clear with B's read pending: clear must be served first.
    for (int i = 0; i < 8; i++) begin
      do_access(i[0], 1, 3'(i), 8'(i + 1), 8'h22, gl, dl);
    end
    do_access(0, 0, 3'd7, 8'h00, 8'h08, gl, dl);
    e.who = 1; e.rdata = 8'h00;
    sb.push_back(e);
    clr_req = 1; b_req = 1; b_we = 0; b_addr = 3'd7;
    saw_clr = 0; got_b = 0;
    start = done_cnt;
    for (int i = 0; i < 20 && !got_b; i++) begin
      @(negedge clk);
      if (o_clr_done) begin
        saw_clr = 1;
        clr_req = 0;
      end
      if (o_b_gnt) begin
        got_b = 1;
        b_req = 0;
        chk("clr_before_b_gnt", saw_clr, 1'b1);
      end
    end
    clr_req = 0; b_req = 0;
    chk("b_gnt_after_clr", got_b, 1'b1);
    for (int i = 0; i < 10 && done_cnt == start; i++) begin
      @(negedge clk);
      #1;
    end
    chk("clr_sb_empty", sb.size(), 0);
    sb.delete();
    do_access(0, 0, 3'd0, 8'h00, 8'h00, gl, dl);

    // Reset during ACCESS of A's write: outputs drop, no done, bank zero, rr back to A.
    do_access(1, 1, 3'd4, 8'h33, 8'h00, gl, dl);
    do_access(0, 0, 3'd4, 8'h00, 8'h33, gl, dl);
    a_req = 1; a_we = 1; a_addr = 3'd4; a_wdata = 8'hAA;
    got_b = 0;
    for (int i = 0; i < 12 && !got_b; i++) begin
      @(negedge clk);
      if (o_a_gnt) got_b = 1;
    end
    chk("abort_gnt_seen", got_b, 1'b1);
    start = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("abort_pulses", {o_a_gnt, o_a_done, o_b_gnt, o_b_done, o_clr_done}, 5'b0);
    chk("abort_rdata", o_rdata, 8'h00);
    a_req = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt - start, 0);
    e.who = 0; e.rdata = 8'h00; sb.push_back(e);
    e.who = 1; e.rdata = 8'h00; sb.push_back(e);
    a_req = 1; a_we = 0; a_addr = 3'd4;
    b_req = 1; b_we = 0; b_addr = 3'd4;
    start = done_cnt;
    for (int i = 0; i < 20 && (done_cnt - start) < 2; i++) begin
      @(negedge clk);
      if (o_a_gnt) a_req = 0;
      if (o_b_gnt) b_req = 0;
      #1;
    end
    a_req = 0; b_req = 0;
    chk("post_reset_done_count", done_cnt - start, 2);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Owns a bank of NREG 8-bit registers built from reg8 instances, and shares that bank between two requesters (A and B) with round-robin arbitration.
- reg8 has no load enable, so this block sequences every access. Addressed registers get new D data; all other registers recirculate Q back to D. The controller also drives the bank's synchronous reset.
- Sits between the two datapath masters (for example the instruction-fetch side and the execute side) and the general-purpose register storage.

Parameters:
- NREG, 8: number of 8-bit registers in the bank; legal range 2..8.
- AW, 3: address width; must satisfy 2^AW >= NREG.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- a_req, input, 1: requester A access request; held until a_gnt.
- a_we, input, 1: A's request type; 1 = write, 0 = read.
- a_addr, input, AW: A's register address.
- a_wdata, input, 8: A's write data.
- a_gnt, output, 1: one-cycle pulse; A's request has been accepted.
- a_done, output, 1: one-cycle pulse; A's access is complete and rdata is valid.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done: same as A, for requester B.
- clr_req, input, 1: request to zero the whole bank.
- clr_done, output, 1: one-cycle pulse; the bank clear is complete.
- rdata, output, 8: read data, registered and shared by both requesters.

Behaviour:
- Reset (reset_n low):
  - FSM returns to IDLE immediately.
  - All gnt/done pulses, clr_done and rdata go to 0; command latches go to 0.
  - Round-robin pointer rr goes to A.
  - Bank synchronous reset is held asserted for as long as reset_n is low, so contents are 0 after the first clk edge during reset.
  - Reset mid-access aborts the access: no done pulse, and no partial write is kept.
- FSM states and transitions:
  - IDLE:
    - clr_req has top priority: go to CLEAR; rr is unchanged.
    - Otherwise, if only one req is high, that requester wins.
    - If both are high, the requester selected by rr wins.
    - The winner's we, addr and wdata are latched into command registers; go to ACCESS.
  - ACCESS: gnt for the winner is high for this one cycle; rr switches to the other requester.
    - Write: the latched wdata drives D of the addressed register; all others get Q. The update lands at the edge that ends ACCESS.
    - Read: rdata <= Q[addr] at that same edge.
    - Next state: DONE.
  - DONE: done for the winner is high for one cycle; rdata holds its value (unchanged after a write). Next state: IDLE.
  - CLEAR: bank reset is asserted for exactly one cycle. Next state: CLRDONE.
  - CLRDONE: clr_done is high for one cycle. Next state: IDLE.
- Latency:
  - req sampled at edge E0 → gnt in cycle E0..E1 → done and rdata valid in cycle E1..E2.
  - Back-to-back accesses: one every 3 cycles.
- Handshake:
  - A requester keeps req and its command stable until it sees gnt.
  - Command inputs are don't-care after gnt.
  - If req is still high in the cycle after done, it is treated as a new request.
- rdata is only meaningful while done is high; it holds until the next read.
- Boundary conditions:
  - Address ≥ NREG: a write is ignored (all registers recirculate); a read returns 0x00. gnt and done still pulse.
  - A read of a register in the access immediately after a write to it returns the new value.
  - clr_req held high alongside a pending req: CLEAR completes first; the request is served on the next IDLE evaluation.
  - Fairness: with both reqs held continuously, grants alternate A, B, A, ...
- The bank's set input is tied low.

Decomposition:
- Shared package holds:
  - the FSM state encoding: IDLE, ACCESS, DONE, CLEAR, CLRDONE (3-bit);
  - requester IDs REQ_A = 0, REQ_B = 1;
  - the constant DW = 8.
- One sub-module, reg_bank:
  - NREG reg8 instances plus a per-register D mux (recirculate or wdata) driven by a one-hot write select;
  - shared sync reset;
  - exposes all Q values as a flat vector.
- Arbitration, FSM and read mux live in reg_bank_arbiter.

Test Plan:
- Reset, then A writes 0x5A to register 3 → a_gnt at cycle 1, a_done at cycle 2; a following read of register 3 returns rdata = 0x5A at a_done.
- a_req and b_req both held high from reset, writing 0x11 (A) and 0x22 (B) to registers 1 and 2 → grant order A, B, A, B; registers hold 0x11 and 0x22.
- Fill registers 0–7 with 0x01–0x08, then pulse clr_req together with b_req → CLEAR is served first; clr_done pulses; B's subsequent read of register 7 returns 0x00.
- With NREG = 6: write 0xFF to address 7, then read address 7 → no register changes; rdata = 0x00; gnt and done still pulse.
- Drop reset_n during ACCESS of a write of 0xAA to register 4 (which held 0x33) → outputs 0 immediately; no done; register 4 = 0x00 after a clk edge in reset; rr points to A.
- Write 0xC3 to register 5, then a read of register 5 in the next access → rdata = 0xC3.
